// File: rtl/jelly_img_mass_center_tracker_defs.sv
// rtl/jelly_img_mass_center_tracker_defs.sv - shared state and status encodings for the mass-center tracker
package jelly_img_mass_center_tracker_defs;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_INIT   = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_CALC   = 3'd3;
    localparam logic [2:0] ST_UPDATE = 3'd4;

    localparam int STATUS_TRACKING_BIT = 0;
    localparam int STATUS_LOST_BIT     = 1;

    localparam logic [1:0] STATUS_NONE     = 2'b00;
    localparam logic [1:0] STATUS_TRACKING = 2'b01;
    localparam logic [1:0] STATUS_LOST     = 2'b10;

endpackage

// File: rtl/jelly_img_window_clamp.sv
// rtl/jelly_img_window_clamp.sv - centre/half/size to inclusive window bounds clamped to the image
module jelly_img_window_clamp #(
    parameter int WIDTH = 14
) (
    input  logic [WIDTH-1:0] centre,
    input  logic [WIDTH-1:0] half,
    input  logic [WIDTH-1:0] size,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    logic [WIDTH:0] lim;
    logic [WIDTH:0] c;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    // One extra bit so centre+half cannot wrap before the clamp.
    always_comb begin
        lim  = {1'b0, size} - (WIDTH+1)'(1);
        c    = ({1'b0, centre} > lim) ? lim : {1'b0, centre};
        sum  = c + {1'b0, half};
        diff = c - {1'b0, half};
        lo   = (c < {1'b0, half}) ? '0 : diff[WIDTH-1:0];
        hi   = (sum > lim) ? lim[WIDTH-1:0] : sum[WIDTH-1:0];
    end

endmodule

// File: rtl/jelly_img_mass_center_tracker.sv
// rtl/jelly_img_mass_center_tracker.sv - recentres the mass-center measurement window on each frame's centroid
module jelly_img_mass_center_tracker
    import jelly_img_mass_center_tracker_defs::*;
#(
    parameter int INDEX_WIDTH = 1,
    parameter int X_WIDTH     = 14,
    parameter int Y_WIDTH     = 14,
    parameter int Q_WIDTH     = 0,
    parameter int LOST_WIDTH  = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic [X_WIDTH-1:0]         param_img_width,
    input  logic [Y_WIDTH-1:0]         param_img_height,
    input  logic [X_WIDTH-1:0]         param_half_w,
    input  logic [Y_WIDTH-1:0]         param_half_h,
    input  logic [X_WIDTH-1:0]         param_init_x,
    input  logic [Y_WIDTH-1:0]         param_init_y,
    input  logic [LOST_WIDTH-1:0]      param_lost_limit,
    input  logic [X_WIDTH+Q_WIDTH-1:0] in_x,
    input  logic [Y_WIDTH+Q_WIDTH-1:0] in_y,
    input  logic                       in_valid,
    input  logic                       in_frame_end,
    input  logic [INDEX_WIDTH-1:0]     ctl_index,
    output logic                       ctl_update,
    output logic [X_WIDTH-1:0]         range_left,
    output logic [X_WIDTH-1:0]         range_right,
    output logic [Y_WIDTH-1:0]         range_top,
    output logic [Y_WIDTH-1:0]         range_bottom,
    output logic                       status_tracking,
    output logic                       status_lost
);

    logic [2:0]             state_q, state_d;
    logic                   ctl_update_q, ctl_update_d;
    logic [X_WIDTH-1:0]     range_left_q, range_left_d, range_right_q, range_right_d;
    logic [Y_WIDTH-1:0]     range_top_q, range_top_d, range_bottom_q, range_bottom_d;
    logic [1:0]             status_q, status_d;
    logic [LOST_WIDTH-1:0]  lost_q, lost_d, lost_inc;
    logic                   pending_q, pending_d;
    logic [X_WIDTH-1:0]     cx_q, cx_d;
    logic [Y_WIDTH-1:0]     cy_q, cy_d;
    logic [INDEX_WIDTH-1:0] idx_q, idx_d;

    logic [X_WIDTH-1:0]     in_cx, win_left, win_right;
    logic [Y_WIDTH-1:0]     in_cy, win_top, win_bottom;
    logic                   unused_frac;

    assign in_cx       = in_x[X_WIDTH+Q_WIDTH-1:Q_WIDTH];
    assign in_cy       = in_y[Y_WIDTH+Q_WIDTH-1:Q_WIDTH];
    assign unused_frac = ^{in_x, in_y};

    jelly_img_window_clamp #(.WIDTH(X_WIDTH)) u_clamp_x (
        .centre (cx_q),
        .half   (param_half_w),
        .size   (param_img_width),
        .lo     (win_left),
        .hi     (win_right)
    );

    jelly_img_window_clamp #(.WIDTH(Y_WIDTH)) u_clamp_y (
        .centre (cy_q),
        .half   (param_half_h),
        .size   (param_img_height),
        .lo     (win_top),
        .hi     (win_bottom)
    );

    always_comb begin
        state_d        = state_q;
        ctl_update_d   = ctl_update_q;
        range_left_d   = range_left_q;
        range_right_d  = range_right_q;
        range_top_d    = range_top_q;
        range_bottom_d = range_bottom_q;
        status_d       = status_q;
        lost_d         = lost_q;
        pending_d      = pending_q;
        cx_d           = cx_q;
        cy_d           = cy_q;
        idx_d          = idx_q;
        lost_inc       = (lost_q == '1) ? lost_q : lost_q + LOST_WIDTH'(1);

        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_INIT;
            end
            ST_INIT: begin
                cx_d     = param_init_x;
                cy_d     = param_init_y;
                status_d = STATUS_LOST;
                state_d  = ST_CALC;
            end
            ST_WAIT: begin
                if (in_valid) begin
                    cx_d     = in_cx;
                    cy_d     = in_cy;
                    lost_d   = '0;
                    status_d = STATUS_TRACKING;
                    state_d  = ST_CALC;
                end else if (in_frame_end) begin
                    if (param_lost_limit != '0 && lost_inc >= param_lost_limit) begin
                        lost_d  = '0;
                        state_d = ST_INIT;
                    end else begin
                        lost_d = lost_inc;
                    end
                end
            end
            ST_CALC: begin
                range_left_d   = win_left;
                range_right_d  = win_right;
                range_top_d    = win_top;
                range_bottom_d = win_bottom;
                idx_d          = ctl_index;
                ctl_update_d   = 1'b1;
                state_d        = ST_UPDATE;
                // The window above already used the old centre; a new one waits its turn.
                if (in_valid) begin
                    cx_d      = in_cx;
                    cy_d      = in_cy;
                    pending_d = 1'b1;
                end
            end
            ST_UPDATE: begin
                if (in_valid) begin
                    cx_d      = in_cx;
                    cy_d      = in_cy;
                    pending_d = 1'b1;
                end
                if (ctl_index != idx_q) begin
                    ctl_update_d = 1'b0;
                    if (pending_q || in_valid) begin
                        pending_d = 1'b0;
                        status_d  = STATUS_TRACKING;
                        state_d   = ST_CALC;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (!enable) begin
            state_d        = ST_IDLE;
            ctl_update_d   = 1'b0;
            pending_d      = 1'b0;
            lost_d         = '0;
            range_left_d   = range_left_q;
            range_right_d  = range_right_q;
            range_top_d    = range_top_q;
            range_bottom_d = range_bottom_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            ctl_update_q   <= 1'b0;
            range_left_q   <= '0;
            range_right_q  <= '1;
            range_top_q    <= '0;
            range_bottom_q <= '1;
            status_q       <= STATUS_NONE;
            lost_q         <= '0;
            pending_q      <= 1'b0;
            cx_q           <= '0;
            cy_q           <= '0;
            idx_q          <= '0;
        end else begin
            state_q        <= state_d;
            ctl_update_q   <= ctl_update_d;
            range_left_q   <= range_left_d;
            range_right_q  <= range_right_d;
            range_top_q    <= range_top_d;
            range_bottom_q <= range_bottom_d;
            status_q       <= status_d;
            lost_q         <= lost_d;
            pending_q      <= pending_d;
            cx_q           <= cx_d;
            cy_q           <= cy_d;
            idx_q          <= idx_d;
        end
    end

    assign ctl_update      = ctl_update_q;
    assign range_left      = range_left_q;
    assign range_right     = range_right_q;
    assign range_top       = range_top_q;
    assign range_bottom    = range_bottom_q;
    assign status_tracking = status_q[STATUS_TRACKING_BIT];
    assign status_lost     = status_q[STATUS_LOST_BIT];

endmodule
